// File: rtl/hms_timer.sv
// Hours:minutes:seconds up/down timer clocked at 1 Hz, with preset load,
// optional auto-reload in countdown mode, and combinational BCD display output.
module hms_timer #(
    parameter int unsigned HOUR_MOD    = 24,
    parameter int unsigned AUTO_RELOAD = 0
) (
    input  logic        clk_1hz,
    input  logic        rst,
    input  logic        en_i,
    input  logic        mode_i,
    input  logic        load_i,
    input  logic        clr_i,
    input  logic [6:0]  preset_h_i,
    input  logic [5:0]  preset_m_i,
    input  logic [5:0]  preset_s_i,
    output logic [6:0]  hours_o,
    output logic [5:0]  mins_o,
    output logic [5:0]  secs_o,
    output logic [23:0] bcd_o,
    output logic        done_o,
    output logic        wrap_o,
    output logic        running_o
);

    localparam logic [6:0] HMax       = 7'(HOUR_MOD - 1);
    localparam logic [5:0] MsMax      = 6'd59;
    localparam bit         AutoReload = (AUTO_RELOAD != 0);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StPause,
        StDone
    } state_e;

    state_e     state_q, state_d;
    logic [6:0] h_q, h_d;
    logic [5:0] m_q, m_d;
    logic [5:0] s_q, s_d;
    logic [6:0] ph_q, ph_d;
    logic [5:0] pm_q, pm_d;
    logic [5:0] ps_q, ps_d;
    logic       done_q, done_d;
    logic       wrap_q, wrap_d;

    logic [6:0] ld_h;
    logic [5:0] ld_m;
    logic [5:0] ld_s;
    logic [6:0] up_h, dn_h;
    logic [5:0] up_m, dn_m;
    logic [5:0] up_s, dn_s;
    logic       up_wrap;
    logic       is_zero;
    logic       dn_zero;

    // Out-of-range preset fields saturate rather than wrap.
    always_comb begin
        ld_h = (preset_h_i > HMax)  ? HMax  : preset_h_i;
        ld_m = (preset_m_i > MsMax) ? MsMax : preset_m_i;
        ld_s = (preset_s_i > MsMax) ? MsMax : preset_s_i;
    end

    always_comb begin
        up_h    = h_q;
        up_m    = m_q;
        up_s    = s_q + 6'd1;
        up_wrap = 1'b0;
        if (s_q >= MsMax) begin
            up_s = 6'd0;
            if (m_q >= MsMax) begin
                up_m = 6'd0;
                if (h_q >= HMax) begin
                    up_h    = 7'd0;
                    up_wrap = 1'b1;
                end else begin
                    up_h = h_q + 7'd1;
                end
            end else begin
                up_m = m_q + 6'd1;
            end
        end
    end

    // Only consumed when the value is non-zero, so the hour borrow never underflows.
    always_comb begin
        dn_h = h_q;
        dn_m = m_q;
        dn_s = s_q - 6'd1;
        if (s_q == 6'd0) begin
            dn_s = MsMax;
            if (m_q != 6'd0) begin
                dn_m = m_q - 6'd1;
            end else begin
                dn_m = MsMax;
                dn_h = h_q - 7'd1;
            end
        end
    end

    assign is_zero = (h_q == 7'd0) && (m_q == 6'd0) && (s_q == 6'd0);
    assign dn_zero = (dn_h == 7'd0) && (dn_m == 6'd0) && (dn_s == 6'd0);

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        m_d     = m_q;
        s_d     = s_q;
        ph_d    = ph_q;
        pm_d    = pm_q;
        ps_d    = ps_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;

        if (clr_i) begin
            state_d = StIdle;
            h_d     = 7'd0;
            m_d     = 6'd0;
            s_d     = 6'd0;
        end else if (load_i) begin
            h_d  = ld_h;
            m_d  = ld_m;
            s_d  = ld_s;
            ph_d = ld_h;
            pm_d = ld_m;
            ps_d = ld_s;
            if (state_q == StDone) begin
                state_d = StIdle;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (en_i) state_d = StRun;
                end
                StRun: begin
                    if (!en_i) begin
                        state_d = StPause;
                    end else if (!mode_i) begin
                        h_d    = up_h;
                        m_d    = up_m;
                        s_d    = up_s;
                        wrap_d = up_wrap;
                    end else if (is_zero) begin
                        // Step due with nothing left to count.
                        if (AutoReload) begin
                            h_d = ph_q;
                            m_d = pm_q;
                            s_d = ps_q;
                        end else begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end
                    end else begin
                        h_d = dn_h;
                        m_d = dn_m;
                        s_d = dn_s;
                        if (dn_zero) begin
                            done_d = 1'b1;
                            if (!AutoReload) state_d = StDone;
                        end
                    end
                end
                StPause: begin
                    if (en_i) state_d = StRun;
                end
                StDone: begin
                    state_d = StDone;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk_1hz or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            h_q     <= 7'd0;
            m_q     <= 6'd0;
            s_q     <= 6'd0;
            ph_q    <= 7'd0;
            pm_q    <= 6'd0;
            ps_q    <= 6'd0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            m_q     <= m_d;
            s_q     <= s_d;
            ph_q    <= ph_d;
            pm_q    <= pm_d;
            ps_q    <= ps_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    assign hours_o   = h_q;
    assign mins_o    = m_q;
    assign secs_o    = s_q;
    assign bcd_o     = {to_bcd(h_q), to_bcd({1'b0, m_q}), to_bcd({1'b0, s_q})};
    assign done_o    = done_q;
    assign wrap_o    = wrap_q;
    assign running_o = (state_q == StRun);

endmodule

// File: tb/tb_hms_timer.sv
// Bench for hms_timer: three instances (24h/no reload, 24h/auto-reload, 1h/no reload)
// share stimulus; expected {h,m,s,done,wrap,running} per edge go through a queue.
module tb_hms_timer;

    logic       clk_1hz = 1'b0;
    logic       rst     = 1'b1;
    logic       en      = 1'b0;
    logic       mode    = 1'b0;
    logic       load    = 1'b0;
    logic       clr     = 1'b0;
    logic [6:0] ph      = 7'd0;
    logic [5:0] pm      = 6'd0;
    logic [5:0] ps      = 6'd0;

    logic [6:0]  hours   [3];
    logic [5:0]  mins    [3];
    logic [5:0]  secs    [3];
    logic [23:0] bcd     [3];
    logic        done    [3];
    logic        wrap    [3];
    logic        running [3];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string            tag;
        logic [2:0][21:0] e;
    } exp_t;

    exp_t sb[$];

    always #5 clk_1hz = ~clk_1hz;

    hms_timer #(.HOUR_MOD(24), .AUTO_RELOAD(0)) u_dut0 (
        .clk_1hz(clk_1hz), .rst(rst), .en_i(en), .mode_i(mode), .load_i(load), .clr_i(clr),
        .preset_h_i(ph), .preset_m_i(pm), .preset_s_i(ps),
        .hours_o(hours[0]), .mins_o(mins[0]), .secs_o(secs[0]), .bcd_o(bcd[0]),
        .done_o(done[0]), .wrap_o(wrap[0]), .running_o(running[0])
    );

    hms_timer #(.HOUR_MOD(24), .AUTO_RELOAD(1)) u_dut1 (
        .clk_1hz(clk_1hz), .rst(rst), .en_i(en), .mode_i(mode), .load_i(load), .clr_i(clr),
        .preset_h_i(ph), .preset_m_i(pm), .preset_s_i(ps),
        .hours_o(hours[1]), .mins_o(mins[1]), .secs_o(secs[1]), .bcd_o(bcd[1]),
        .done_o(done[1]), .wrap_o(wrap[1]), .running_o(running[1])
    );

    hms_timer #(.HOUR_MOD(1), .AUTO_RELOAD(0)) u_dut2 (
        .clk_1hz(clk_1hz), .rst(rst), .en_i(en), .mode_i(mode), .load_i(load), .clr_i(clr),
        .preset_h_i(ph), .preset_m_i(pm), .preset_s_i(ps),
        .hours_o(hours[2]), .mins_o(mins[2]), .secs_o(secs[2]), .bcd_o(bcd[2]),
        .done_o(done[2]), .wrap_o(wrap[2]), .running_o(running[2])
    );

    function automatic logic [21:0] pk(input int h, input int m, input int s,
                                       input bit d, input bit w, input bit r);
        return {7'(h), 6'(m), 6'(s), d, w, r};
    endfunction

    function automatic logic [21:0] obs(input int k);
        return {hours[k], mins[k], secs[k], done[k], wrap[k], running[k]};
    endfunction

    task automatic push(input string tag, input logic [21:0] e0, input logic [21:0] e1,
                        input logic [21:0] e2);
        exp_t x;
        x.tag = tag;
        x.e   = {e2, e1, e0};
        sb.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk_1hz);
        #1;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (obs(k) !== pk(0, 0, 0, 0, 0, 0) || bcd[k] !== 24'h0) begin
                n_err++;
                $display("FAIL reset_async dut%0d: got {h,m,s,d,w,r}=%h bcd=%h want 0/0",
                         k, obs(k), bcd[k]);
            end
        end
        en = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (obs(k) !== pk(0, 0, 0, 0, 0, 0)) begin
                n_err++;
                $display("FAIL reset_held dut%0d: got %h want %h", k, obs(k), pk(0, 0, 0, 0, 0, 0));
            end
        end
        en  = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_count_up();
        exp_t x;
        en   = 1'b1;
        mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push("count_up", pk(0, 0, i, 0, 0, 1), pk(0, 0, i, 0, 0, 1), pk(0, 0, i, 0, 0, 1));
            tick();
            x = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obs(k) !== x.e[k]) begin
                    n_err++;
                    $display("FAIL %s dut%0d edge%0d: got %h want %h", x.tag, k, i, obs(k), x.e[k]);
                end
            end
        end
    endtask

    task automatic test_wrap();
        exp_t x;
        load = 1'b1;
        ph   = 7'd23;
        pm   = 6'd59;
        ps   = 6'd58;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: push("wrap", pk(23, 59, 58, 0, 0, 1), pk(23, 59, 58, 0, 0, 1),
                        pk(0, 59, 58, 0, 0, 1));
                1: push("wrap", pk(23, 59, 59, 0, 0, 1), pk(23, 59, 59, 0, 0, 1),
                        pk(0, 59, 59, 0, 0, 1));
                2: push("wrap", pk(0, 0, 0, 0, 1, 1), pk(0, 0, 0, 0, 1, 1), pk(0, 0, 0, 0, 1, 1));
                default: push("wrap", pk(0, 0, 1, 0, 0, 1), pk(0, 0, 1, 0, 0, 1),
                              pk(0, 0, 1, 0, 0, 1));
            endcase
            tick();
            load = 1'b0;
            x = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obs(k) !== x.e[k]) begin
                    n_err++;
                    $display("FAIL %s dut%0d edge%0d: got %h want %h", x.tag, k, i, obs(k), x.e[k]);
                end
            end
            if (i == 2) begin
                n_cmp++;
                if (bcd[0] !== 24'h000000) begin
                    n_err++;
                    $display("FAIL wrap_bcd: got %h want 000000", bcd[0]);
                end
            end
        end
    endtask

    task automatic test_countdown();
        exp_t x;
        int   v;
        load = 1'b1;
        mode = 1'b1;
        ph   = 7'd0;
        pm   = 6'd1;
        ps   = 6'd1;
        for (int i = 0; i < 66; i++) begin
            if (i == 0) begin
                push("cd_load", pk(0, 1, 1, 0, 0, 1), pk(0, 1, 1, 0, 0, 1), pk(0, 1, 1, 0, 0, 1));
            end else if (i <= 61) begin
                v = 61 - i;
                push("cd_step", pk(0, v / 60, v % 60, v == 0, 0, v != 0),
                     pk(0, v / 60, v % 60, v == 0, 0, 1),
                     pk(0, v / 60, v % 60, v == 0, 0, v != 0));
            end else if (i == 62) begin
                push("cd_hold", pk(0, 0, 0, 0, 0, 0), pk(0, 1, 1, 0, 0, 1), pk(0, 0, 0, 0, 0, 0));
            end else if (i == 63) begin
                push("cd_hold", pk(0, 0, 0, 0, 0, 0), pk(0, 1, 0, 0, 0, 1), pk(0, 0, 0, 0, 0, 0));
            end else if (i == 64) begin
                load = 1'b1;
                ps   = 6'd5;
                pm   = 6'd0;
                push("cd_reload_from_done", pk(0, 0, 5, 0, 0, 0), pk(0, 0, 5, 0, 0, 1),
                     pk(0, 0, 5, 0, 0, 0));
            end else begin
                push("cd_idle_to_run", pk(0, 0, 5, 0, 0, 1), pk(0, 0, 4, 0, 0, 1),
                     pk(0, 0, 5, 0, 0, 1));
            end
            tick();
            load = 1'b0;
            x = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obs(k) !== x.e[k]) begin
                    n_err++;
                    $display("FAIL %s dut%0d edge%0d: got %h want %h", x.tag, k, i, obs(k), x.e[k]);
                end
            end
        end
    endtask

    task automatic test_clamp();
        exp_t x;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clr  = (i != 1);
            load = (i != 0);
            ph   = (i == 1) ? 7'd99 : 7'd5;
            pm   = (i == 1) ? 6'd63 : 6'd5;
            ps   = (i == 1) ? 6'd63 : 6'd5;
            if (i == 1) begin
                push("clamp", pk(23, 59, 59, 0, 0, 0), pk(23, 59, 59, 0, 0, 0),
                     pk(0, 59, 59, 0, 0, 0));
            end else begin
                push("clr", pk(0, 0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0, 0), pk(0, 0, 0, 0, 0, 0));
            end
            tick();
            x = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obs(k) !== x.e[k]) begin
                    n_err++;
                    $display("FAIL %s dut%0d edge%0d: got %h want %h", x.tag, k, i, obs(k), x.e[k]);
                end
            end
            if (i == 1) begin
                n_cmp++;
                if (bcd[0] !== 24'h235959 || bcd[2] !== 24'h005959) begin
                    n_err++;
                    $display("FAIL clamp_bcd: got %h/%h want 235959/005959", bcd[0], bcd[2]);
                end
            end
        end
        clr  = 1'b0;
        load = 1'b0;
    endtask

    task automatic test_zero_entry();
        exp_t x;
        en   = 1'b1;
        mode = 1'b1;
        push("zero_enter_run", pk(0, 0, 0, 0, 0, 1), pk(0, 0, 0, 0, 0, 1), pk(0, 0, 0, 0, 0, 1));
        push("zero_step", pk(0, 0, 0, 1, 0, 0), pk(23, 59, 59, 0, 0, 1), pk(0, 0, 0, 1, 0, 0));
        push("zero_after", pk(0, 0, 0, 0, 0, 0), pk(23, 59, 58, 0, 0, 1), pk(0, 0, 0, 0, 0, 0));
        for (int i = 0; i < 3; i++) begin
            tick();
            x = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obs(k) !== x.e[k]) begin
                    n_err++;
                    $display("FAIL %s dut%0d edge%0d: got %h want %h", x.tag, k, i, obs(k), x.e[k]);
                end
            end
        end
    endtask

    task automatic test_pause_resume();
        exp_t x;
        int   s;
        logic r;
        for (int i = 0; i < 10; i++) begin
            clr  = (i == 0);
            en   = !(i == 0 || (i >= 4 && i <= 6));
            mode = (i == 9);
            case (i)
                0:       begin s = 0; r = 1'b0; end
                1, 2, 3: begin s = i - 1; r = 1'b1; end
                4, 5, 6: begin s = 2; r = 1'b0; end
                7:       begin s = 2; r = 1'b1; end
                8:       begin s = 3; r = 1'b1; end
                default: begin s = 2; r = 1'b1; end
            endcase
            push("pause", pk(0, 0, s, 0, 0, r), pk(0, 0, s, 0, 0, r), pk(0, 0, s, 0, 0, r));
            tick();
            x = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obs(k) !== x.e[k]) begin
                    n_err++;
                    $display("FAIL %s dut%0d edge%0d: got %h want %h", x.tag, k, i, obs(k), x.e[k]);
                end
            end
        end
        clr  = 1'b0;
        mode = 1'b0;
        #3 rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (obs(k) !== pk(0, 0, 0, 0, 0, 0) || bcd[k] !== 24'h0) begin
                n_err++;
                $display("FAIL midrun_reset dut%0d: got %h bcd=%h want 0", k, obs(k), bcd[k]);
            end
        end
        #1 rst = 1'b1;
        push("post_reset", pk(0, 0, 0, 0, 0, 1), pk(0, 0, 0, 0, 0, 1), pk(0, 0, 0, 0, 0, 1));
        push("post_reset", pk(0, 0, 1, 0, 0, 1), pk(0, 0, 1, 0, 0, 1), pk(0, 0, 1, 0, 0, 1));
        for (int i = 0; i < 2; i++) begin
            tick();
            x = sb.pop_front();
            for (int k = 0; k < 3; k++) begin
                n_cmp++;
                if (obs(k) !== x.e[k]) begin
                    n_err++;
                    $display("FAIL %s dut%0d edge%0d: got %h want %h", x.tag, k, i, obs(k), x.e[k]);
                end
            end
        end
    endtask

    // done and wrap must never coincide on any instance.
    always @(negedge clk_1hz) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                if (done[k] === 1'b1 && wrap[k] === 1'b1) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL pulse_exclusive dut%0d: done=1 wrap=1 want not both", k);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_count_up();
        test_wrap();
        test_countdown();
        test_clamp();
        test_zero_entry();
        test_pause_resume();
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
